// File: rtl/sram_march_bist.sv
// March C- built-in self-test engine for a single-port SRAM (RW0 port).
// Runs M0..M5 over addresses 0..DEPTH-1 and reports the first mismatch.
module sram_march_bist #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int DATA_W = 176,
  parameter int MASK_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_fail,
  output logic [ADDR_W-1:0] io_fail_addr,
  output logic [2:0]        io_fail_element,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_CHK, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                phase_q, phase_d;      // 0 = read cycle A, 1 = write cycle B
  logic                rd_pend_q;             // an M5 read was issued last cycle
  logic [ADDR_W-1:0]   rd_addr_q;             // address of that M5 read
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]          fail_elem_q, fail_elem_d;

  // Per-element attributes of the read/write elements M1..M4
  logic                elem_up;
  logic                elem_rd_ones;
  logic [2:0]          elem_num;
  state_t              elem_next;
  logic [ADDR_W-1:0]   elem_next_addr;

  // Access and compare controls decoded from the registered state
  logic                rw_en, rw_we, rw_ones;
  logic [ADDR_W-1:0]   rw_addr;
  logic                cmp_en, cmp_ones, mismatch;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [2:0]          cmp_elem;

  // Decode direction, expected read pattern and successor of M1..M4
  always_comb begin
    elem_up        = 1'b0;
    elem_rd_ones   = 1'b0;
    elem_num       = 3'd0;
    elem_next      = S_IDLE;
    elem_next_addr = '0;
    case (state_q)
      S_M1: begin elem_up = 1'b1; elem_rd_ones = 1'b0; elem_num = 3'd1; elem_next = S_M2; elem_next_addr = '0;        end
      S_M2: begin elem_up = 1'b1; elem_rd_ones = 1'b1; elem_num = 3'd2; elem_next = S_M3; elem_next_addr = LAST_ADDR; end
      S_M3: begin elem_up = 1'b0; elem_rd_ones = 1'b0; elem_num = 3'd3; elem_next = S_M4; elem_next_addr = LAST_ADDR; end
      S_M4: begin elem_up = 1'b0; elem_rd_ones = 1'b1; elem_num = 3'd4; elem_next = S_M5; elem_next_addr = '0;        end
      default: ;
    endcase
  end

  // Next-state, address sequencing, SRAM access decode and read compare
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    rw_en       = 1'b0;
    rw_we       = 1'b0;
    rw_ones     = 1'b0;
    rw_addr     = '0;
    cmp_en      = 1'b0;
    cmp_ones    = 1'b0;
    cmp_addr    = addr_q;
    cmp_elem    = elem_num;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (io_start) begin
          state_d     = S_M0;
          addr_d      = '0;
          phase_d     = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      S_M0: begin
        rw_en   = 1'b1;
        rw_we   = 1'b1;
        rw_addr = addr_q;
        if (addr_q == LAST_ADDR) begin
          state_d = S_M1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        rw_en   = 1'b1;
        rw_addr = addr_q;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          // Cycle B: write the inverse pattern while checking cycle A's read
          rw_we    = 1'b1;
          rw_ones  = ~elem_rd_ones;
          cmp_en   = 1'b1;
          cmp_ones = elem_rd_ones;
          phase_d  = 1'b0;
          if (elem_up ? (addr_q == LAST_ADDR) : (addr_q == '0)) begin
            state_d = elem_next;
            addr_d  = elem_next_addr;
          end else begin
            addr_d = elem_up ? addr_q + 1'b1 : addr_q - 1'b1;
          end
        end
      end
      S_M5: begin
        rw_en    = 1'b1;
        rw_addr  = addr_q;
        cmp_en   = rd_pend_q;
        cmp_addr = rd_addr_q;
        cmp_elem = 3'd5;
        if (addr_q == LAST_ADDR) state_d = S_CHK;
        else                     addr_d  = addr_q + 1'b1;
      end
      S_CHK: begin
        cmp_en   = rd_pend_q;
        cmp_addr = rd_addr_q;
        cmp_elem = 3'd5;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    mismatch = cmp_en && (RW0_rdata != {DATA_W{cmp_ones}});
    if (mismatch) begin
      state_d     = S_DONE;
      fail_d      = 1'b1;
      fail_addr_d = cmp_addr;
      fail_elem_d = cmp_elem;
    end
  end

  // State, counters and fail record; reset aborts immediately to IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      rd_pend_q   <= (state_q == S_M5);
      rd_addr_q   <= addr_q;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign io_busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign io_done         = (state_q == S_DONE);
  assign io_fail         = fail_q;
  assign io_fail_addr    = fail_addr_q;
  assign io_fail_element = fail_elem_q;
  assign RW0_en          = rw_en;
  assign RW0_wmode       = rw_we;
  assign RW0_addr        = rw_addr;
  assign RW0_wmask       = {MASK_W{rw_we}};
  assign RW0_wdata       = {DATA_W{rw_we & rw_ones}};

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: a DEPTH=64 instance with a fault-injecting SRAM
// and a DEPTH=48 instance with an ideal SRAM, checked cycle by cycle against
// an algorithmic March C- trace model.
module tb_sram_march_bist;
  localparam int AW = 6;
  localparam int DW = 176;
  localparam int MW = 8;
  localparam logic [DW-1:0] STUCK_MASK = DW'(1) << 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start64 = 1'b0;
  logic start48 = 1'b0;
  always #5 clk = ~clk;

  logic          d64_busy, d64_done, d64_fail, d64_en, d64_we;
  logic [AW-1:0] d64_faddr, d64_addr;
  logic [2:0]    d64_felem;
  logic [MW-1:0] d64_wmask;
  logic [DW-1:0] d64_wdata, rdata64;
  logic          d48_busy, d48_done, d48_fail, d48_en, d48_we;
  logic [AW-1:0] d48_faddr, d48_addr;
  logic [2:0]    d48_felem;
  logic [MW-1:0] d48_wmask;
  logic [DW-1:0] d48_wdata, rdata48;

  sram_march_bist #(.ADDR_W(AW), .DEPTH(64), .DATA_W(DW), .MASK_W(MW)) u_dut64 (
    .clock(clk), .reset(rst), .io_start(start64),
    .io_busy(d64_busy), .io_done(d64_done), .io_fail(d64_fail),
    .io_fail_addr(d64_faddr), .io_fail_element(d64_felem),
    .RW0_addr(d64_addr), .RW0_en(d64_en), .RW0_wmode(d64_we),
    .RW0_wmask(d64_wmask), .RW0_wdata(d64_wdata), .RW0_rdata(rdata64));

  sram_march_bist #(.ADDR_W(AW), .DEPTH(48), .DATA_W(DW), .MASK_W(MW)) u_dut48 (
    .clock(clk), .reset(rst), .io_start(start48),
    .io_busy(d48_busy), .io_done(d48_done), .io_fail(d48_fail),
    .io_fail_addr(d48_faddr), .io_fail_element(d48_felem),
    .RW0_addr(d48_addr), .RW0_en(d48_en), .RW0_wmode(d48_we),
    .RW0_wmask(d48_wmask), .RW0_wdata(d48_wdata), .RW0_rdata(rdata48));

  // fault: 0 none, 1 bit 100 of word 37 stuck-at-1,
  // 2 a write taking bit 0 of word 6 from 1 to 0 flips bit 0 of word 5
  int fault = 0;
  logic [DW-1:0] sram64 [64];
  logic [DW-1:0] sram48 [64];

  // SRAM models: one-cycle read latency
  always @(posedge clk) begin
    if (d64_en) begin
      if (d64_we) begin
        if (fault == 2 && d64_addr == 6'd6 && sram64[6][0] === 1'b1 && !d64_wdata[0])
          sram64[5][0] <= ~sram64[5][0];
        sram64[d64_addr] <= d64_wdata;
      end else begin
        rdata64 <= sram64[d64_addr] | ((fault == 1 && d64_addr == 6'd37) ? STUCK_MASK : '0);
      end
    end
  end

  always @(posedge clk) begin
    if (d48_en) begin
      if (d48_we) sram48[d48_addr] <= d48_wdata;
      else        rdata48 <= sram48[d48_addr];
    end
  end

  // ---------------- reference model: expected access per busy cycle ----------------
  typedef struct {bit en; bit we; bit ones; int addr;} acc_t;
  typedef struct packed {
    logic busy; logic done; logic fail; logic [AW-1:0] faddr; logic [2:0] felem;
    logic en; logic we; logic [AW-1:0] addr; logic [MW-1:0] wmask; logic [DW-1:0] wdata;
  } obs_t;

  acc_t tr[$];
  bit   exp_fail;
  int   exp_faddr, exp_felem;
  logic [DW-1:0] mm [64];

  int vec_cnt = 0;
  int mis_cnt = 0;
  int mode = 0;      // 0 no check, 1 all outputs zero, 2 follow trace
  int k = 0;         // cycle index after the start edge
  bit sel48 = 1'b0;

  function automatic logic [DW-1:0] m_read(input int a, input int flt);
    logic [DW-1:0] v;
    v = mm[a];
    if (flt == 1 && a == 37) v[100] = 1'b1;
    return v;
  endfunction

  task automatic m_write(input int a, input bit b, input int flt);
    if (flt == 2 && a == 6 && mm[6][0] === 1'b1 && !b) mm[5][0] = ~mm[5][0];
    mm[a] = {DW{b}};
  endtask

  task automatic push(input bit en, input bit we, input bit ones, input int a);
    acc_t t;
    t.en = en; t.we = we; t.ones = ones; t.addr = a;
    tr.push_back(t);
  endtask

  task automatic build_trace(input int depth, input int flt);
    logic [DW-1:0] v, prev;
    bit rp;
    int a;
    tr.delete();
    exp_fail = 1'b0; exp_faddr = 0; exp_felem = 0;
    prev = '0;
    for (int i = 0; i < 64; i++) mm[i] = '0;
    for (int i = 0; i < depth; i++) begin
      push(1, 1, 0, i);
      m_write(i, 1'b0, flt);
    end
    for (int e = 1; e <= 4 && !exp_fail; e++) begin
      rp = (e == 2 || e == 4);
      for (int j = 0; j < depth && !exp_fail; j++) begin
        a = (e <= 2) ? j : depth - 1 - j;
        push(1, 0, 0, a);
        v = m_read(a, flt);
        push(1, 1, !rp, a);
        m_write(a, !rp, flt);
        if (v !== {DW{rp}}) begin exp_fail = 1'b1; exp_faddr = a; exp_felem = e; end
      end
    end
    for (int j = 0; j <= depth && !exp_fail; j++) begin
      if (j < depth) push(1, 0, 0, j);
      else           push(0, 0, 0, 0);
      if (j > 0 && prev !== '0) begin exp_fail = 1'b1; exp_faddr = j - 1; exp_felem = 5; end
      if (j < depth) prev = m_read(j, flt);
    end
    $display("run depth=%0d fault=%0d: expect length=%0d fail=%0d addr=%0d element=%0d",
             depth, flt, tr.size(), exp_fail, exp_faddr, exp_felem);
  endtask

  task automatic check_lit(input string name, input int act, input int expv);
    vec_cnt++;
    if (act != expv) begin
      mis_cnt++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  task automatic check_outputs();
    obs_t a, e;
    acc_t t;
    a = sel48 ? {d48_busy, d48_done, d48_fail, d48_faddr, d48_felem, d48_en, d48_we, d48_addr, d48_wmask, d48_wdata}
              : {d64_busy, d64_done, d64_fail, d64_faddr, d64_felem, d64_en, d64_we, d64_addr, d64_wmask, d64_wdata};
    e = '0;
    if (mode == 2) begin
      if (k < tr.size()) begin
        t = tr[k];
        e.busy  = 1'b1;
        e.en    = t.en;
        e.we    = t.we;
        e.addr  = AW'(t.addr);
        e.wmask = t.we ? '1 : '0;
        e.wdata = (t.we && t.ones) ? '1 : '0;
        if (!t.en) a.addr = '0;
      end else begin
        e.done  = 1'b1;
        e.fail  = exp_fail;
        e.faddr = AW'(exp_faddr);
        e.felem = 3'(exp_felem);
        a.addr  = '0;
      end
    end
    vec_cnt++;
    if (a !== e) begin
      mis_cnt++;
      $display("FAIL outputs k=%0d dut48=%0b got busy=%b done=%b fail=%b faddr=%0d elem=%0d en=%b we=%b addr=%0d mask=%h wdata=%h want busy=%b done=%b fail=%b faddr=%0d elem=%0d en=%b we=%b addr=%0d mask=%h wdata=%h",
               k, sel48, a.busy, a.done, a.fail, a.faddr, a.felem, a.en, a.we, a.addr, a.wmask, a.wdata,
               e.busy, e.done, e.fail, e.faddr, e.felem, e.en, e.we, e.addr, e.wmask, e.wdata);
    end
    if (sel48 && mode == 2 && a.en) begin
      vec_cnt++;
      if (a.addr > 6'd47) begin
        mis_cnt++;
        $display("FAIL addr_bound48 k=%0d: got addr %0d, want <= 47", k, a.addr);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mode != 0) check_outputs();
    k++;
  endtask

  // Pulse (or hold) start so it is sampled at the next rising edge, then arm the model
  task automatic launch(input bit s48, input int flt, input int depth, input bit hold);
    #1;
    sel48 = s48;
    fault = flt;
    if (s48) start48 = 1'b1;
    else     start64 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin start48 = 1'b0; start64 = 1'b0; end
    build_trace(depth, flt);
    mode = 2;
    k = 0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    mode = 1;
    tick(); tick();
    #1 rst = 1'b0;
    tick(); tick();

    // Ideal SRAM, full passing run
    launch(0, 0, 64, 0);
    check_lit("pass64_length", tr.size(), 641);
    check_lit("pass64_fail", exp_fail, 0);
    check_lit("m3_first_addr", tr[320].addr, 63);
    check_lit("m3_last_addr", tr[446].addr, 0);
    check_lit("m4_first_addr", tr[448].addr, 63);
    repeat (644) tick();

    // Coupling 6 -> 5, visible only in descending order
    launch(0, 2, 64, 0);
    check_lit("couple_length", tr.size(), 438);
    check_lit("couple_fail", exp_fail, 1);
    check_lit("couple_addr", exp_faddr, 5);
    check_lit("couple_element", exp_felem, 3);
    repeat (441) tick();

    // Stuck-at-1 bit, with start held high through the first 100 busy cycles
    launch(0, 1, 64, 1);
    check_lit("stuck_length", tr.size(), 140);
    check_lit("stuck_fail", exp_fail, 1);
    check_lit("stuck_addr", exp_faddr, 37);
    check_lit("stuck_element", exp_felem, 1);
    repeat (100) tick();
    #1 start64 = 1'b0;
    repeat (43) tick();

    // Start in DONE restarts cleanly; reset asserted mid-M2 at cycle 250
    launch(0, 0, 64, 0);
    repeat (251) tick();
    #2 rst = 1'b1;
    mode = 1;
    #1 check_outputs();
    tick(); tick(); tick();
    #1 rst = 1'b0;
    tick(); tick();

    // Full passing run after the aborted one
    launch(0, 0, 64, 0);
    repeat (644) tick();

    // Non-power-of-two depth
    launch(1, 0, 48, 0);
    check_lit("pass48_length", tr.size(), 481);
    repeat (484) tick();

    mode = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
